// File: rtl/adc_channel_block.sv
// One oscilloscope acquisition channel: ADC clock generation, sample capture and
// decimating average, front-end control registers, circular capture buffer and readout.
`timescale 1ns/1ps
module adc_channel_block #(
  parameter int BITS_ADC                  = 8,
  parameter int BITS_DAC                  = 10,
  parameter int REG_ADDR_WIDTH            = 8,
  parameter int REG_DATA_WIDTH            = 16,
  parameter int TX_DATA_WIDTH             = 8,
  parameter int RAM_DATA_WIDTH            = 8,
  parameter int RAM_SIZE                  = 4096,
  parameter int ADC_CLK_DIV_WIDTH         = 32,
  parameter int MOVING_AVERAGE_ACUM_WIDTH = 13,
  parameter logic [REG_ADDR_WIDTH-1:0] ADDR_CH_SETTINGS      = 8,
  parameter logic [REG_ADDR_WIDTH-1:0] ADDR_DAC_VALUE        = 9,
  parameter logic [REG_ADDR_WIDTH-1:0] ADDR_ADC_CLK_DIV_L    = 1,
  parameter logic [REG_ADDR_WIDTH-1:0] ADDR_ADC_CLK_DIV_H    = 2,
  parameter logic [REG_ADDR_WIDTH-1:0] ADDR_N_MOVING_AVERAGE = 5,
  parameter logic [7:0]                   DEFAULT_CH_SETTINGS      = 8'h80,
  parameter logic [BITS_DAC-1:0]          DEFAULT_DAC_VALUE        = '0,
  parameter logic [ADC_CLK_DIV_WIDTH-1:0] DEFAULT_ADC_CLK_DIV      = 1,
  parameter logic [4:0]                   DEFAULT_N_MOVING_AVERAGE = '0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [BITS_ADC-1:0]       adc_input,
  output logic                      adc_oe,
  output logic                      adc_clk_o,
  output logic [2:0]                Att_Sel,
  output logic [2:0]                Gain_Sel,
  output logic                      DC_Coupling,
  output logic                      Channel_On,
  input  logic                      rqst_data,
  input  logic                      we,
  input  logic [REG_DATA_WIDTH-1:0] num_samples,
  input  logic [REG_ADDR_WIDTH-1:0] register_addr,
  input  logic [REG_DATA_WIDTH-1:0] register_data,
  input  logic                      register_rdy,
  output logic [BITS_DAC-1:0]       dac_value,
  output logic [BITS_ADC-1:0]       adc_data_o,
  output logic                      adc_rdy_o,
  output logic [TX_DATA_WIDTH-1:0]  tx_data,
  output logic                      tx_rdy,
  output logic                      tx_eof,
  input  logic                      tx_ack
);

  localparam int DIV_HALF_W = ADC_CLK_DIV_WIDTH / 2;
  localparam int RAM_AW     = $clog2(RAM_SIZE);
  localparam int ACC_W      = MOVING_AVERAGE_ACUM_WIDTH;
  localparam logic [4:0] N_MAX = 5'(MOVING_AVERAGE_ACUM_WIDTH - BITS_ADC);
  localparam logic [REG_DATA_WIDTH-1:0] RAM_SIZE_W = REG_DATA_WIDTH'(RAM_SIZE);

  typedef enum logic [1:0] {IDLE, READ, SEND} rd_state_t;

  logic [7:0]                   ch_settings;
  logic [BITS_DAC-1:0]          dac_reg;
  logic [DIV_HALF_W-1:0]        div_l;
  logic [DIV_HALF_W-1:0]        div_h;
  logic [4:0]                   n_reg;
  logic [ADC_CLK_DIV_WIDTH-1:0] divider;
  logic [ADC_CLK_DIV_WIDTH-1:0] div_eff;
  logic [ADC_CLK_DIV_WIDTH-1:0] clk_cnt;
  logic                         hit_n;
  logic                         n_change;
  logic [4:0]                   n_eff;
  logic [BITS_ADC-1:0]          raw_p0;
  logic                         vld_p0;
  logic [ACC_W-1:0]             acc;
  logic [ACC_W-1:0]             acc_sum;
  logic [ACC_W-1:0]             smp_cnt;
  logic                         group_done;
  logic [RAM_AW-1:0]            wr_ptr;
  logic [RAM_AW-1:0]            rd_ptr;
  logic [REG_DATA_WIDTH-1:0]    remaining;
  logic [REG_DATA_WIDTH-1:0]    req_len;
  rd_state_t                    state;
  logic [RAM_DATA_WIDTH-1:0]    mem [RAM_SIZE];

  // Truncating divide of the accumulated sum by 2^n.
  function automatic logic [BITS_ADC-1:0] avg_shift(input logic [ACC_W-1:0] sum,
                                                    input logic [4:0] n);
    return BITS_ADC'(sum >> n);
  endfunction

  assign adc_oe      = 1'b0;
  assign Att_Sel     = ch_settings[2:0];
  assign Gain_Sel    = ch_settings[5:3];
  assign DC_Coupling = ch_settings[6];
  assign Channel_On  = ch_settings[7];
  assign dac_value   = dac_reg;

  assign hit_n    = register_rdy && (register_addr == ADDR_N_MOVING_AVERAGE);
  assign n_change = hit_n && (register_data[4:0] != n_reg);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ch_settings <= DEFAULT_CH_SETTINGS;
      dac_reg     <= DEFAULT_DAC_VALUE;
      div_l       <= DEFAULT_ADC_CLK_DIV[DIV_HALF_W-1:0];
      div_h       <= DEFAULT_ADC_CLK_DIV[ADC_CLK_DIV_WIDTH-1:DIV_HALF_W];
      n_reg       <= DEFAULT_N_MOVING_AVERAGE;
    end else if (register_rdy) begin
      if (register_addr == ADDR_CH_SETTINGS)   ch_settings <= register_data[7:0];
      if (register_addr == ADDR_DAC_VALUE)     dac_reg     <= register_data[BITS_DAC-1:0];
      if (register_addr == ADDR_ADC_CLK_DIV_L) div_l       <= register_data[DIV_HALF_W-1:0];
      if (register_addr == ADDR_ADC_CLK_DIV_H) div_h       <= register_data[DIV_HALF_W-1:0];
      if (hit_n)                               n_reg       <= register_data[4:0];
    end
  end

  assign divider = {div_h, div_l};
  assign div_eff = (divider == '0) ? ADC_CLK_DIV_WIDTH'(1) : divider;

  // Stage p0: ADC clock generation and raw capture on the falling ADC clock wrap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clk_cnt   <= '0;
      adc_clk_o <= 1'b0;
      vld_p0    <= 1'b0;
    end else begin
      vld_p0 <= 1'b0;
      if (clk_cnt >= div_eff) begin
        clk_cnt   <= '0;
        adc_clk_o <= ~adc_clk_o;
        vld_p0    <= adc_clk_o;
      end else begin
        clk_cnt <= clk_cnt + ADC_CLK_DIV_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clk_cnt >= div_eff && adc_clk_o) raw_p0 <= adc_input;
  end

  assign n_eff      = (n_reg > N_MAX) ? N_MAX : n_reg;
  assign acc_sum    = acc + ACC_W'(raw_p0);
  assign group_done = (smp_cnt == ((ACC_W'(1) << n_eff) - ACC_W'(1)));

  // Stage p1: decimating average, one output strobe per 2^n raw samples.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc        <= '0;
      smp_cnt    <= '0;
      adc_rdy_o  <= 1'b0;
      adc_data_o <= '0;
    end else begin
      adc_rdy_o <= 1'b0;
      if (n_change) begin
        acc     <= '0;
        smp_cnt <= '0;
      end else if (vld_p0) begin
        if (group_done) begin
          adc_data_o <= avg_shift(acc_sum, n_eff);
          adc_rdy_o  <= 1'b1;
          acc        <= '0;
          smp_cnt    <= '0;
        end else begin
          acc     <= acc_sum;
          smp_cnt <= smp_cnt + ACC_W'(1);
        end
      end
    end
  end

  // Stage p2: circular capture buffer, oldest data overwritten on wrap.
  always_ff @(posedge clk) begin
    if (adc_rdy_o && we) mem[wr_ptr] <= adc_data_o;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                 wr_ptr <= '0;
    else if (adc_rdy_o && we) wr_ptr <= wr_ptr + RAM_AW'(1);
  end

  assign req_len = (num_samples > RAM_SIZE_W) ? RAM_SIZE_W : num_samples;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      rd_ptr    <= '0;
      remaining <= '0;
      tx_data   <= '0;
      tx_rdy    <= 1'b0;
      tx_eof    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (rqst_data && !we && num_samples != '0) begin
            rd_ptr    <= wr_ptr - req_len[RAM_AW-1:0];
            remaining <= req_len;
            state     <= READ;
          end
        end
        READ: begin
          tx_data <= mem[rd_ptr];
          tx_rdy  <= 1'b1;
          tx_eof  <= (remaining == REG_DATA_WIDTH'(1));
          state   <= SEND;
        end
        SEND: begin
          if (tx_ack) begin
            tx_rdy    <= 1'b0;
            tx_eof    <= 1'b0;
            rd_ptr    <= rd_ptr + RAM_AW'(1);
            remaining <= remaining - REG_DATA_WIDTH'(1);
            state     <= (remaining == REG_DATA_WIDTH'(1)) ? IDLE : READ;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adc_channel_block.sv
// Randomized self-checking bench for adc_channel_block against a behavioural model
// of sample averaging and buffered readout.
`timescale 1ns/1ps
module tb_adc_channel_block;

  logic        clk;
  logic        rst;
  logic [7:0]  adc_input;
  logic        adc_oe;
  logic        adc_clk_o;
  logic [2:0]  Att_Sel;
  logic [2:0]  Gain_Sel;
  logic        DC_Coupling;
  logic        Channel_On;
  logic        rqst_data;
  logic        we;
  logic [15:0] num_samples;
  logic [7:0]  register_addr;
  logic [15:0] register_data;
  logic        register_rdy;
  logic [9:0]  dac_value;
  logic [7:0]  adc_data_o;
  logic        adc_rdy_o;
  logic [7:0]  tx_data;
  logic        tx_rdy;
  logic        tx_eof;
  logic        tx_ack;

  int     n_checks = 0;
  int     n_pass   = 0;
  longint cyc      = 0;

  logic [7:0] avg_q[$];
  logic [7:0] hist[$];
  longint     rdy_cyc[$];

  adc_channel_block dut (
    .clk(clk), .rst(rst), .adc_input(adc_input), .adc_oe(adc_oe), .adc_clk_o(adc_clk_o),
    .Att_Sel(Att_Sel), .Gain_Sel(Gain_Sel), .DC_Coupling(DC_Coupling), .Channel_On(Channel_On),
    .rqst_data(rqst_data), .we(we), .num_samples(num_samples),
    .register_addr(register_addr), .register_data(register_data), .register_rdy(register_rdy),
    .dac_value(dac_value), .adc_data_o(adc_data_o), .adc_rdy_o(adc_rdy_o),
    .tx_data(tx_data), .tx_rdy(tx_rdy), .tx_eof(tx_eof), .tx_ack(tx_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Observe every averaged output; those written while we=1 form the buffer history.
  always @(negedge clk) begin
    if (rst && adc_rdy_o) begin
      avg_q.push_back(adc_data_o);
      rdy_cyc.push_back(cyc);
      if (we) hist.push_back(adc_data_o);
    end
  end

  task automatic wait_adc_edge(input bit lvl);
    bit prev;
    bit done;
    prev = adc_clk_o;
    done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(posedge clk); #1;
      if (prev != lvl && adc_clk_o == lvl) done = 1'b1;
      prev = adc_clk_o;
    end
    if (!done) begin
      n_checks++;
      $display("FAIL adc_clk_edge: no edge to %0d within 400 clk", lvl);
    end
  endtask

  // Called during the high ADC clock phase; returns just after the next rising edge.
  task automatic send_sample(input logic [7:0] v);
    adc_input = v;
    wait_adc_edge(1'b0);
    wait_adc_edge(1'b1);
  endtask

  task automatic write_reg(input logic [7:0] a, input logic [15:0] d);
    @(negedge clk);
    register_addr = a;
    register_data = d;
    register_rdy  = 1'b1;
    @(negedge clk);
    register_rdy  = 1'b0;
  endtask

  task automatic dump(input int num, input logic [7:0] exp[$], input string tag);
    bit seen;
    num_samples = 16'(num);
    @(negedge clk); rqst_data = 1'b1;
    @(negedge clk); rqst_data = 1'b0;
    for (int k = 0; k < exp.size(); k++) begin
      seen = 1'b0;
      for (int t = 0; t < 50 && !seen; t++) begin
        if (tx_rdy) seen = 1'b1;
        else @(negedge clk);
      end
      n_checks++;
      if (!seen) begin
        $display("FAIL %s_tx_rdy word %0d: tx_rdy=0 required 1 within 50 clk", tag, k);
        return;
      end
      n_pass++;
      n_checks++;
      if (tx_data !== exp[k] || tx_eof !== (k == exp.size() - 1))
        $display("FAIL %s_word %0d: data=%0d eof=%0b required data=%0d eof=%0b",
                 tag, k, tx_data, tx_eof, exp[k], (k == exp.size() - 1));
      else n_pass++;
      tx_ack = 1'b1;
      @(negedge clk);
      tx_ack = 1'b0;
      n_checks++;
      if (tx_rdy !== 1'b0) $display("FAIL %s_ack_drop word %0d: tx_rdy=%0b required 0", tag, k, tx_rdy);
      else n_pass++;
    end
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (tx_rdy) seen = 1'b1;
    end
    n_checks++;
    if (seen) $display("FAIL %s_idle: tx_rdy=1 after last word, required 0", tag);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst = 1'b0; adc_input = '0; rqst_data = 0; we = 0; num_samples = '0;
    register_addr = '0; register_data = '0; register_rdy = 0; tx_ack = 0;
    repeat (3) @(posedge clk); #1;
    n_checks++;
    if ({adc_clk_o, adc_rdy_o, adc_data_o, tx_rdy, tx_eof, tx_data} !== 20'h0)
      $display("FAIL reset_outputs: clk=%0b rdy=%0b data=%0h txrdy=%0b eof=%0b txdata=%0h required all 0",
               adc_clk_o, adc_rdy_o, adc_data_o, tx_rdy, tx_eof, tx_data);
    else n_pass++;
    @(negedge clk); rst = 1'b1;
    #1;
    n_checks++;
    if ({Channel_On, DC_Coupling, Gain_Sel, Att_Sel} !== 8'h80 || adc_oe !== 1'b0 || dac_value !== 10'd0)
      $display("FAIL reset_regs: settings=%0h oe=%0b dac=%0d required 80 0 0",
               {Channel_On, DC_Coupling, Gain_Sel, Att_Sel}, adc_oe, dac_value);
    else n_pass++;
  endtask

  task automatic test_clock_period(input int expected, input string tag);
    longint c0;
    wait_adc_edge(1'b1);
    c0 = cyc;
    wait_adc_edge(1'b1);
    n_checks++;
    if (cyc - c0 != longint'(expected))
      $display("FAIL %s: adc_clk period %0d clk required %0d", tag, cyc - c0, expected);
    else n_pass++;
  endtask

  task automatic test_registers();
    logic [9:0] d;
    write_reg(8'd8, 16'h00D5);
    #1;
    n_checks++;
    if ({Att_Sel, Gain_Sel, DC_Coupling, Channel_On} !== {3'd5, 3'd2, 1'b1, 1'b1})
      $display("FAIL settings_write: att=%0d gain=%0d dc=%0b on=%0b required 5 2 1 1",
               Att_Sel, Gain_Sel, DC_Coupling, Channel_On);
    else n_pass++;
    d = 10'($urandom_range(1, 1023));
    write_reg(8'd9, {6'h3F, d});
    #1;
    n_checks++;
    if (dac_value !== d) $display("FAIL dac_write: dac=%0d required %0d", dac_value, d);
    else n_pass++;
    write_reg(8'h33, 16'($urandom));
    @(negedge clk);
    register_addr = 8'd8; register_data = 16'h0012; register_rdy = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({Channel_On, DC_Coupling, Gain_Sel, Att_Sel} !== 8'hD5 || dac_value !== d)
      $display("FAIL ignored_writes: settings=%0h dac=%0d required d5 %0d",
               {Channel_On, DC_Coupling, Gain_Sel, Att_Sel}, dac_value, d);
    else n_pass++;
  endtask

  task automatic test_divider();
    bit ok;
    write_reg(8'd1, 16'd4);
    write_reg(8'd2, 16'd0);
    test_clock_period(10, "div4_period");
    adc_input = 8'h3C;
    wait_adc_edge(1'b1);
    wait_adc_edge(1'b1);
    avg_q.delete(); rdy_cyc.delete();
    repeat (3) wait_adc_edge(1'b1);
    ok = (avg_q.size() >= 2) && (rdy_cyc.size() >= 2);
    if (ok) ok = (rdy_cyc[1] - rdy_cyc[0] == 10) && (avg_q[0] === 8'h3C) && (avg_q[1] === 8'h3C);
    n_checks++;
    if (!ok) $display("FAIL div4_samples: count=%0d spacing/data wrong, required 3c every 10 clk", avg_q.size());
    else n_pass++;
    write_reg(8'd1, 16'd0);
    test_clock_period(4, "div0_period");
  endtask

  task automatic test_average_fixed();
    wait_adc_edge(1'b1);
    write_reg(8'd5, 16'd2);
    avg_q.delete();
    send_sample(8'd10); send_sample(8'd20); send_sample(8'd30); send_sample(8'd40);
    repeat (3) @(posedge clk); #1;
    n_checks++;
    if (avg_q.size() != 1 || avg_q[0] !== 8'd25)
      $display("FAIL avg_fixed: outputs=%0d first=%0d required 1 output of 25",
               avg_q.size(), (avg_q.size() > 0) ? avg_q[0] : 8'd0);
    else n_pass++;
  endtask

  task automatic test_average_random();
    int nl[4] = '{3, 0, 6, 1};
    int ng, gs, groups, sum;
    logic [7:0] v;
    logic [7:0] exp[$];
    for (int t = 0; t < 4; t++) begin
      ng = (nl[t] > 5) ? 5 : nl[t];
      gs = 1 << ng;
      groups = (ng == 5) ? 1 : 3;
      exp.delete();
      wait_adc_edge(1'b1);
      write_reg(8'd5, 16'(nl[t]));
      avg_q.delete();
      for (int g = 0; g < groups; g++) begin
        sum = 0;
        for (int s = 0; s < gs; s++) begin
          v = 8'($urandom_range(0, 255));
          sum += int'(v);
          send_sample(v);
        end
        exp.push_back(8'(sum / gs));
      end
      repeat (3) @(posedge clk); #1;
      n_checks++;
      if (avg_q.size() < groups || (ng > 0 && avg_q.size() != groups))
        $display("FAIL avg_count n=%0d: outputs=%0d required %0d", nl[t], avg_q.size(), groups);
      else n_pass++;
      for (int g = 0; g < groups && g < avg_q.size(); g++) begin
        n_checks++;
        if (avg_q[g] !== exp[g])
          $display("FAIL avg_value n=%0d group %0d: got %0d required %0d", nl[t], g, avg_q[g], exp[g]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_ramp_dump();
    logic [7:0] exp[$];
    wait_adc_edge(1'b1);
    write_reg(8'd5, 16'd0);
    wait_adc_edge(1'b1);
    we = 1'b1;
    for (int i = 1; i <= 8; i++) send_sample(8'(i));
    we = 1'b0;
    exp = '{8'd5, 8'd6, 8'd7, 8'd8};
    dump(4, exp, "ramp");
  endtask

  task automatic test_ignored_requests();
    bit seen;
    num_samples = 16'd0;
    @(negedge clk); rqst_data = 1'b1;
    @(negedge clk); rqst_data = 1'b0;
    seen = 1'b0;
    repeat (20) begin @(negedge clk); if (tx_rdy) seen = 1'b1; end
    n_checks++;
    if (seen) $display("FAIL rqst_num0: tx_rdy=1 required 0");
    else n_pass++;
    num_samples = 16'd4;
    we = 1'b1;
    @(negedge clk); rqst_data = 1'b1;
    @(negedge clk); rqst_data = 1'b0;
    seen = 1'b0;
    repeat (20) begin @(negedge clk); if (tx_rdy) seen = 1'b1; end
    we = 1'b0;
    n_checks++;
    if (seen) $display("FAIL rqst_we1: tx_rdy=1 required 0");
    else n_pass++;
  endtask

  task automatic test_overflow();
    logic [7:0] ov[$];
    logic [7:0] exp[$];
    logic [7:0] v;
    wait_adc_edge(1'b1);
    we = 1'b1;
    for (int i = 0; i < 4096 + 3; i++) begin
      v = 8'($urandom);
      ov.push_back(v);
      send_sample(v);
    end
    we = 1'b0;
    for (int i = 3; i < ov.size(); i++) exp.push_back(ov[i]);
    dump(4096, exp, "overflow");
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp[$];
    int num;
    wait_adc_edge(1'b1);
    we = 1'b1;
    for (int i = 0; i < 20; i++) send_sample(8'($urandom));
    we = 1'b0;
    for (int r = 0; r < 2; r++) begin
      num = $urandom_range(1, 20);
      exp.delete();
      for (int i = hist.size() - num; i < hist.size(); i++) exp.push_back(hist[i]);
      dump(num, exp, "b2b");
    end
  endtask

  task automatic test_reset_abort();
    bit seen;
    num_samples = 16'd6;
    @(negedge clk); rqst_data = 1'b1;
    @(negedge clk); rqst_data = 1'b0;
    seen = 1'b0;
    for (int t = 0; t < 20 && !seen; t++) begin @(negedge clk); if (tx_rdy) seen = 1'b1; end
    #1 rst = 1'b0;
    #1;
    n_checks++;
    if (!seen || tx_rdy !== 1'b0 || adc_clk_o !== 1'b0 || {Channel_On, DC_Coupling, Gain_Sel, Att_Sel} !== 8'h80)
      $display("FAIL reset_abort: started=%0b tx_rdy=%0b adc_clk=%0b settings=%0h required 1 0 0 80",
               seen, tx_rdy, adc_clk_o, {Channel_On, DC_Coupling, Gain_Sel, Att_Sel});
    else n_pass++;
    @(negedge clk); rst = 1'b1;
    seen = 1'b0;
    repeat (15) begin @(negedge clk); if (tx_rdy) seen = 1'b1; end
    n_checks++;
    if (seen) $display("FAIL reset_abort_idle: tx_rdy=1 after reset, required 0");
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_clock_period(4, "reset_period");
    test_registers();
    test_divider();
    test_average_fixed();
    test_average_random();
    test_ramp_dump();
    test_ignored_requests();
    test_back_to_back();
    test_overflow();
    test_reset_abort();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
